// File: rtl/celery_pkg.sv
// Shared raster types: screen coordinates and signed fixed-point formats with 16 fractional bits.
package celery_pkg;
  localparam int COORD_W   = 10;
  localparam int FRAC_BITS = 16;

  typedef logic [COORD_W-1:0] screen_coord_t;
  typedef logic signed [31:0] fp32_t;
  typedef logic signed [47:0] fp48_t;

  // Edge i: E = a[i]*(x+0.5) + b[i]*(y+0.5) + c[i]; z interpolated about vertex (x0, y0).
  typedef struct packed {
    logic                valid;
    logic                ccw;
    logic [2:0]          top_left;
    fp32_t [2:0]         a;
    fp32_t [2:0]         b;
    fp48_t [2:0]         c;
    screen_coord_t       min_x;
    screen_coord_t       max_x;
    screen_coord_t       min_y;
    screen_coord_t       max_y;
    fp32_t               x0;
    fp32_t               y0;
    fp32_t               z0;
    fp32_t               dzdx;
    fp32_t               dzdy;
  } triangle_setup_t;
endpackage

// File: rtl/triangle_rasterizer.sv
// Walks a triangle's bounding box in raster order and streams inside pixels as (x, y, z) fragments.
// Optional macro CELERY_RAST_BACKFACE_CULL_EN: clockwise (ccw=0) triangles are rejected at INIT.
//
// state   | meaning
// IDLE    | waiting for a setup record
// INIT    | evaluate edges and depth at the box origin
// SCAN    | one pixel per cycle, stalls only on an inside pixel with a full output slot
// DRAIN   | last fragment still waiting for downstream
// DONE    | one-cycle completion pulse
module triangle_rasterizer
  import celery_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  triangle_setup_t setup_in,
  input  logic            setup_valid,
  output logic            setup_ready,
  output logic            frag_valid,
  input  logic            frag_ready,
  output screen_coord_t   frag_x,
  output screen_coord_t   frag_y,
  output fp32_t           frag_z,
  output logic            busy,
  output logic            done
);
  typedef enum logic [2:0] {S_IDLE, S_INIT, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t          r_state, w_next;
  triangle_setup_t r_setup;
  screen_coord_t   r_cx, r_cy;
  fp48_t           r_e [3];
  fp48_t           r_e_row [3];
  fp32_t           r_z, r_z_row;
  fp48_t           w_e_init [3];
  fp32_t           w_z_init;
  logic            w_reject, w_inside, w_slot_free, w_emit, w_advance, w_last;

  function automatic logic signed [63:0] mul_q16(input logic signed [63:0] k,
                                                 input logic signed [63:0] v);
    mul_q16 = (k * v) >>> FRAC_BITS;
  endfunction

  function automatic logic signed [31:0] centre_q16(input screen_coord_t c);
    centre_q16 = $signed({{(16-COORD_W){1'b0}}, c, 1'b1, {(FRAC_BITS-1){1'b0}}});
  endfunction

  function automatic logic edge_pass(input fp48_t e, input logic ccw, input logic tl);
    if (e == '0)   edge_pass = tl;
    else if (ccw)  edge_pass = (e > 48'sd0);
    else           edge_pass = (e < 48'sd0);
  endfunction

`ifdef CELERY_RAST_BACKFACE_CULL_EN
  assign w_reject = !r_setup.valid || !r_setup.ccw;
`else
  assign w_reject = !r_setup.valid;
`endif

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_e_init[i] = 48'(mul_q16(64'($signed(r_setup.a[i])), 64'(centre_q16(r_setup.min_x)))
                      + mul_q16(64'($signed(r_setup.b[i])), 64'(centre_q16(r_setup.min_y)))
                      + 64'($signed(r_setup.c[i])));
    end
    w_z_init = 32'(64'($signed(r_setup.z0))
      + mul_q16(64'($signed(r_setup.dzdx)), 64'(centre_q16(r_setup.min_x) - $signed(r_setup.x0)))
      + mul_q16(64'($signed(r_setup.dzdy)), 64'(centre_q16(r_setup.min_y) - $signed(r_setup.y0))));
  end

  assign w_inside    = edge_pass(r_e[0], r_setup.ccw, r_setup.top_left[0])
                    && edge_pass(r_e[1], r_setup.ccw, r_setup.top_left[1])
                    && edge_pass(r_e[2], r_setup.ccw, r_setup.top_left[2]);
  assign w_slot_free = !frag_valid || frag_ready;
  assign w_emit      = (r_state == S_SCAN) && w_inside && w_slot_free;
  // Outside pixels never touch the output register, so they may pass a stalled fragment.
  assign w_advance   = (r_state == S_SCAN) && (!w_inside || w_slot_free);
  assign w_last      = (r_cx == r_setup.max_x) && (r_cy == r_setup.max_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    setup_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        setup_ready = 1'b1;
        busy        = 1'b0;
        if (setup_valid) w_next = S_INIT;
      end
      S_INIT:  w_next = w_reject ? S_DONE : S_SCAN;
      S_SCAN:  if (w_advance && w_last) w_next = S_DRAIN;
      S_DRAIN: if (w_slot_free) w_next = S_DONE;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_setup <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_z     <= '0;
      r_z_row <= '0;
      for (int i = 0; i < 3; i++) begin
        r_e[i]     <= '0;
        r_e_row[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE && setup_valid) r_setup <= setup_in;
      if (r_state == S_INIT) begin
        r_cx    <= r_setup.min_x;
        r_cy    <= r_setup.min_y;
        r_z     <= w_z_init;
        r_z_row <= w_z_init;
        for (int i = 0; i < 3; i++) begin
          r_e[i]     <= w_e_init[i];
          r_e_row[i] <= w_e_init[i];
        end
      end else if (w_advance) begin
        if (r_cx < r_setup.max_x) begin
          r_cx <= r_cx + screen_coord_t'(1);
          r_z  <= r_z + r_setup.dzdx;
          for (int i = 0; i < 3; i++) r_e[i] <= r_e[i] + 48'($signed(r_setup.a[i]));
        end else begin
          r_cx    <= r_setup.min_x;
          r_cy    <= r_cy + screen_coord_t'(1);
          r_z_row <= r_z_row + r_setup.dzdy;
          r_z     <= r_z_row + r_setup.dzdy;
          for (int i = 0; i < 3; i++) begin
            r_e_row[i] <= r_e_row[i] + 48'($signed(r_setup.b[i]));
            r_e[i]     <= r_e_row[i] + 48'($signed(r_setup.b[i]));
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frag_valid <= 1'b0;
      frag_x     <= '0;
      frag_y     <= '0;
      frag_z     <= '0;
    end else if (w_emit) begin
      frag_valid <= 1'b1;
      frag_x     <= r_cx;
      frag_y     <= r_cy;
      frag_z     <= r_z;
    end else if (frag_ready) begin
      frag_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_triangle_rasterizer.sv
// Self-checking bench for triangle_rasterizer: directed cases plus random triangles vs a per-pixel model.
module tb_triangle_rasterizer;
  import celery_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  triangle_setup_t setup_in;
  logic            setup_valid, setup_ready, frag_valid, frag_ready, busy, done;
  screen_coord_t   frag_x, frag_y;
  fp32_t           frag_z;

  triangle_rasterizer dut (
    .clk(clk), .rst_n(rst_n), .setup_in(setup_in), .setup_valid(setup_valid),
    .setup_ready(setup_ready), .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y), .frag_z(frag_z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] z;
    int          k;
  } frag_t;

  frag_t exp_q[$];
  frag_t got_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  int    seen_done, first_k;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Edge i runs from vertex i to vertex i+1; interior is positive for counter-clockwise winding.
  function automatic triangle_setup_t gen_tri(input int x0, input int y0, input int x1, input int y1,
                                              input int x2, input int y2, input logic [2:0] tl,
                                              input logic [31:0] z0, input logic [31:0] dzdx,
                                              input logic [31:0] dzdy);
    triangle_setup_t s;
    int     vx[3], vy[3];
    longint dx, dy, area;
    int     mnx, mxx, mny, mxy;
    s  = '0;
    vx = '{x0, x1, x2};
    vy = '{y0, y1, y2};
    for (int i = 0; i < 3; i++) begin
      dx = longint'(vx[(i+1)%3] - vx[i]);
      dy = longint'(vy[(i+1)%3] - vy[i]);
      s.a[i] = 32'(-dy * 65536);
      s.b[i] = 32'(dx * 65536);
      s.c[i] = 48'((dy * vx[i] - dx * vy[i]) * 65536);
    end
    area = longint'((x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0));
    s.valid    = (area != 0);
    s.ccw      = (area > 0);
    s.top_left = tl;
    mnx = (x0 < x1) ? ((x0 < x2) ? x0 : x2) : ((x1 < x2) ? x1 : x2);
    mny = (y0 < y1) ? ((y0 < y2) ? y0 : y2) : ((y1 < y2) ? y1 : y2);
    mxx = (x0 > x1) ? ((x0 > x2) ? x0 : x2) : ((x1 > x2) ? x1 : x2);
    mxy = (y0 > y1) ? ((y0 > y2) ? y0 : y2) : ((y1 > y2) ? y1 : y2);
    mxx = (mxx - 1 < mnx) ? mnx : mxx - 1;
    mxy = (mxy - 1 < mny) ? mny : mxy - 1;
    s.min_x = 10'(mnx);
    s.max_x = 10'(mxx);
    s.min_y = 10'(mny);
    s.max_y = 10'(mxy);
    s.x0    = 32'(x0 * 65536);
    s.y0    = 32'(y0 * 65536);
    s.z0    = z0;
    s.dzdx  = dzdx;
    s.dzdy  = dzdy;
    return s;
  endfunction

  // Reference: evaluates every pixel centre of the box directly from the closed-form edge/depth equations.
  function automatic void model(input triangle_setup_t s);
    exp_q.delete();
    if (!s.valid) return;
`ifdef CELERY_RAST_BACKFACE_CULL_EN
    if (!s.ccw) return;
`endif
    for (int y = int'(s.min_y); y <= int'(s.max_y); y++) begin
      for (int x = int'(s.min_x); x <= int'(s.max_x); x++) begin
        longint px, py, e;
        logic   in_b;
        frag_t  f;
        px   = longint'(x) * 65536 + 32768;
        py   = longint'(y) * 65536 + 32768;
        in_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
          e = ((longint'($signed(s.a[i])) * px) >>> 16) + ((longint'($signed(s.b[i])) * py) >>> 16)
              + longint'($signed(s.c[i]));
          if (e == 0)     in_b &= s.top_left[i];
          else if (s.ccw) in_b &= (e > 0);
          else            in_b &= (e < 0);
        end
        if (in_b) begin
          f.x = x;
          f.y = y;
          f.k = 0;
          f.z = 32'(longint'($signed(s.z0))
                + ((longint'($signed(s.dzdx)) * (px - longint'($signed(s.x0)))) >>> 16)
                + ((longint'($signed(s.dzdy)) * (py - longint'($signed(s.y0)))) >>> 16));
          exp_q.push_back(f);
        end
      end
    end
  endfunction

  // mode 0: ready always 1; mode 1: ready 1,0,0,1 repeating; mode 2: random ready.
  task automatic run_tri(input triangle_setup_t s, input int mode, input string tag);
    int            k;
    logic          stalled;
    screen_coord_t hx, hy;
    fp32_t         hz;
    frag_t         f;
    model(s);
    got_q.delete();
    seen_done = -1;
    first_k   = -1;
    stalled   = 1'b0;
    hx = '0; hy = '0; hz = '0;
    @(negedge clk);
    setup_in    = s;
    setup_valid = 1'b1;
    frag_ready  = 1'b1;
    check({tag, " ready before"}, 64'(setup_ready), 64'd1);
    @(posedge clk);
    #1 setup_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (seen_done < 0 && k < 3000) begin
      if (stalled) check({tag, " stall hold"}, 64'({frag_x, frag_y, frag_z}), 64'({hx, hy, hz}));
      if (k == 1) check({tag, " ready low"}, 64'(setup_ready), 64'd0);
      case (mode)
        0:       frag_ready = 1'b1;
        1:       frag_ready = (k % 4 == 0) || (k % 4 == 3);
        default: frag_ready = 1'($urandom_range(0, 1));
      endcase
      if (frag_valid) begin
        if (first_k < 0) first_k = k;
        if (frag_ready) begin
          f.x = int'(frag_x);
          f.y = int'(frag_y);
          f.z = frag_z;
          f.k = k;
          got_q.push_back(f);
        end
      end
      stalled = frag_valid && !frag_ready;
      hx = frag_x; hy = frag_y; hz = frag_z;
      if (done) seen_done = k;
      @(negedge clk);
      k++;
    end
    frag_ready = 1'b1;
    check({tag, " done seen"}, 64'(seen_done >= 0), 64'd1);
    check({tag, " done pulse width"}, 64'(done), 64'd0);
    check({tag, " ready after done"}, 64'(setup_ready), 64'd1);
    check({tag, " frag count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, " frag xyz"}, 64'({10'(got_q[i].x), 10'(got_q[i].y), got_q[i].z}),
            64'({10'(exp_q[i].x), 10'(exp_q[i].y), exp_q[i].z}));
  endtask

  initial begin
    triangle_setup_t s;
    int nf, k;
    rst_n       = 1'b0;
    setup_valid = 1'b0;
    frag_ready  = 1'b1;
    setup_in    = '0;
    #12;
    check("reset setup_ready", 64'(setup_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset frag_valid", 64'(frag_valid), 64'd0);
    check("reset frag_xyz", 64'({frag_x, frag_y, frag_z}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    s = gen_tri(0, 0, 2, 2, 4, 4, 3'b111, 32'h1234, 32'h100, 32'h200);
    run_tri(s, 0, "degenerate");
    check("degenerate done time", 64'(seen_done), 64'd1);
    check("degenerate no frags", 64'(got_q.size()), 64'd0);

    s = gen_tri(0, 0, 4, 0, 0, 4, 3'b000, 32'h0001_0000, 32'h0000_4000, 32'hFFFF_8000);
    run_tri(s, 0, "right tl0");
    check("right tl0 count", 64'(got_q.size()), 64'd6);
    check("right tl0 first at T+2", 64'(first_k), 64'd2);

    s = gen_tri(0, 0, 4, 0, 0, 4, 3'b010, 32'h0001_0000, 32'h0000_4000, 32'hFFFF_8000);
    run_tri(s, 0, "right tl1");
    check("right tl1 count", 64'(got_q.size()), 64'd10);

    run_tri(s, 1, "backpressure");
    check("backpressure count", 64'(got_q.size()), 64'd10);

    s = gen_tri(0, 0, 40, 0, 0, 40, 3'b000, 32'h0040_0000, 32'h0000_0321, 32'h0000_1000);
    s.min_x = 10'd2; s.max_x = 10'd5; s.min_y = 10'd3; s.max_y = 10'd5;
    run_tri(s, 0, "full box");
    check("full box count", 64'(got_q.size()), 64'd12);
    for (int i = 0; i < got_q.size(); i++)
      check("full box consecutive", 64'(got_q[i].k), 64'(2 + i));
    check("full box done time", 64'(seen_done), 64'd14);

    s = gen_tri(0, 0, 0, 4, 4, 0, 3'b000, 32'h0002_0000, 32'h0000_2000, 32'h0000_2000);
    run_tri(s, 0, "backface");
`ifdef CELERY_RAST_BACKFACE_CULL_EN
    check("backface count", 64'(got_q.size()), 64'd0);
`else
    check("backface count", 64'(got_q.size()), 64'd6);
`endif

    s = gen_tri(0, 0, 4, 0, 0, 4, 3'b010, 32'h0, 32'h0001_0000, 32'h0);
    @(negedge clk);
    setup_in    = s;
    setup_valid = 1'b1;
    frag_ready  = 1'b1;
    @(posedge clk);
    #1 setup_valid = 1'b0;
    nf = 0;
    k  = 0;
    while (nf < 3 && k < 100) begin
      @(negedge clk);
      if (frag_valid && frag_ready) nf++;
      k++;
    end
    check("reset mid-scan frags", 64'(nf), 64'd3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset mid-scan frag_valid", 64'(frag_valid), 64'd0);
    check("reset mid-scan busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset mid-scan ready", 64'(setup_ready), 64'd1);
    s = gen_tri(1, 1, 9, 2, 3, 8, 3'b101, 32'h00AB_0000, 32'hFFFF_F000, 32'h0000_0800);
    run_tri(s, 2, "after reset");

    for (int n = 0; n < 20; n++) begin
      s = gen_tri(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), int'($urandom_range(0, 11)),
                  3'($urandom_range(0, 7)), $urandom,
                  32'($urandom_range(0, 2097151)) - 32'd1048576,
                  32'($urandom_range(0, 2097151)) - 32'd1048576);
      run_tri(s, int'($urandom_range(0, 2)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/triangle_rasterizer.md
# triangle_rasterizer

Consumes one `triangle_setup_t` record per triangle from the setup unit and walks the setup-computed bounding box in raster order. At each pixel centre it evaluates the three edge functions incrementally and emits a fragment stream (x, y, z) downstream over a valid/ready handshake. It sits between triangle setup and the fragment pipeline (depth test and texturing), and accepts a new triangle only when fully idle.

## Interface
- No parameters. Screen size, `screen_coord_t`, `fp32_t`, `fp48_t` and `triangle_setup_t` come from `celery_pkg`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `setup_in` in `triangle_setup_t`: triangle record. Sampled only on the accept edge.
- `setup_valid` in 1: record present. Driven from setup `done`.
- `setup_ready` out 1: high iff state is IDLE.
- `frag_valid` out 1: fragment present.
- `frag_ready` in 1: downstream accepts the fragment.
- `frag_x`, `frag_y` out `screen_coord_t`: pixel coordinate.
- `frag_z` out `fp32_t`: interpolated depth.
- `busy` out 1: high iff state is not IDLE.
- `done` out 1: one-cycle pulse when the triangle is finished.

## Operation
- **States:** IDLE, INIT, SCAN, DRAIN, DONE.
- **IDLE:** on `setup_valid && setup_ready`, latch `setup_in` and go to INIT.
- **INIT (1 cycle):**
  - If `valid==0` (degenerate triangle), go to DONE.
  - Otherwise set cx=min_x, cy=min_y.
  - Evaluate Ei = ai·(cx+0.5) + bi·(cy+0.5) + ci for each edge, in fp48 with the package fixed-point scaling. Full-width product, truncated to fp48.
  - Copy Ei into Ei_row. Compute z_row = z0 + dzdx·(cx+0.5−x0) + dzdy·(cy+0.5−y0), and set z = z_row.
  - Go to SCAN.
- **Inside test, per edge:**
  - ccw=1: E>0, or E==0 && top_left.
  - ccw=0: E<0, or E==0 && top_left.
  - A pixel is inside iff all three edges pass.
- **SCAN:** evaluate the current pixel.
  - The output slot is free when `!frag_valid || frag_ready`.
  - If inside and the slot is free: register cx, cy, z into the frag outputs, set `frag_valid`, and advance.
  - If inside and the slot is not free: hold everything.
  - If outside: advance, even while the output is stalled. Advancing never drops a held fragment.
- **Advance:**
  - If cx<max_x: cx++, Ei += ai, z += dzdx.
  - Else (row end): cx=min_x, cy++, Ei_row += bi, Ei = Ei_row, z_row += dzdy, z = z_row.
  - Advancing from (max_x, max_y) goes to DRAIN instead.
- **DRAIN:** wait until `frag_valid==0` or `frag_ready==1`, then go to DONE.
- **DONE:** pulse `done` for one cycle, then go to IDLE.
- **Fragment handshake:** `frag_valid` clears on an accept edge when no new fragment loads that edge. While `frag_valid && !frag_ready`, the frag outputs are stable.
- **Arithmetic:** edge and row accumulators are fp48. z and z_row are fp32 and wrap on overflow. The gradients are used as supplied; normalisation is upstream's responsibility.
- **Bounding box:** min > max on either axis never occurs; setup clamps to the screen.
- **Reset:** `rst_n` low at any time aborts the triangle and drops any pending fragment.

## Timing
- **Reset values:** state IDLE, `setup_ready`=1, `busy`=0, `done`=0, `frag_valid`=0, `frag_x`/`frag_y`/`frag_z`=0.
- **Accept edge = T:**
  - INIT runs during cycle T..T+1.
  - The first pixel is evaluated in T+1..T+2.
  - If that pixel is inside, `frag_valid` goes high after edge T+2.
- **Throughput:** one pixel evaluated per cycle. With `frag_ready` held at 1, a box of N pixels takes N SCAN cycles.
- **`done`:** high in the cycle after DRAIN completes. A degenerate triangle gives `done` in T+1..T+2, with no fragments.
- **`setup_ready`:** low from T+1 until `done` has been high for one cycle.

## Configuration
- Macro: `CELERY_RAST_BACKFACE_CULL_EN`.
- **Defined:** a triangle with ccw=0 is treated like `valid==0`. INIT goes to DONE and no fragments are emitted.
- **Undefined:** both windings are rasterized using the polarity rule above.

## Test plan
- **Degenerate:** `valid=0` → zero fragments; `done` pulses in T+1..T+2; `setup_ready` is back high one cycle later.
- **Right triangle:** (0,0),(4,0),(0,4), ccw, `frag_ready`=1 → 6 fragments with x+y≤2 in raster order (0,0),(1,0),(2,0),(0,1),(1,1),(0,2). Add the 4 pixels with x+y=3 iff the hypotenuse edge has `top_left`=1. Each `frag_z` equals the reference-model value exactly.
- **Backpressure:** same triangle, `frag_ready` toggling 1,0,0,1,… → identical fragment sequence, no loss or duplicates, outputs stable while stalled.
- **Full coverage:** a box fully inside the triangle, 4×3 pixels → 12 fragments on consecutive cycles starting at T+2.
- **Reset mid-scan:** assert `rst_n`=0 after the 3rd fragment → `frag_valid`=0 immediately, `setup_ready`=1 after release. A following triangle rasterizes correctly.
- **Backface cull:** ccw=0 triangle → zero fragments with `CELERY_RAST_BACKFACE_CULL_EN` defined; the mirrored fragment set without it.
